// File: rtl/madd_eval_pkg.sv
// Shared types and helpers for exhaustive error evaluation of 6-in/4-out
// approximate multiply-add netlists.
package madd_eval_pkg;

    localparam int N_IN_W  = 6;
    localparam int N_OUT_W = 4;

    // Operand field placement inside the stimulus vector {c, b, a}
    localparam int A_LSB = 0;
    localparam int B_LSB = 2;
    localparam int C_LSB = 4;
    localparam int OP_W  = 2;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } eval_state_t;

    // Exact reference a*b + c, range 0..12, one bit wider than the netlist output
    function automatic logic [N_OUT_W:0] exact_madd(input logic [N_IN_W-1:0] vec);
        logic [N_OUT_W:0] a;
        logic [N_OUT_W:0] b;
        logic [N_OUT_W:0] c;
        logic [N_OUT_W:0] prod;
        a    = (N_OUT_W+1)'(vec[A_LSB +: OP_W]);
        b    = (N_OUT_W+1)'(vec[B_LSB +: OP_W]);
        c    = (N_OUT_W+1)'(vec[C_LSB +: OP_W]);
        prod = a * b;
        return prod + c;
    endfunction

endpackage

// File: rtl/madd_abs_err.sv
// Combinational absolute difference of two unsigned values of equal width.
module madd_abs_err #(
    parameter int W = 5
) (
    input  logic [W-1:0] exact,
    input  logic [W-1:0] approx,
    output logic [W-1:0] abs_err
);

    // Subtract the smaller from the larger so the result never wraps
    always_comb begin
        if (exact >= approx) begin
            abs_err = exact - approx;
        end else begin
            abs_err = approx - exact;
        end
    end

endmodule

// File: rtl/madd_err_evaluator.sv
// Sweeps every input vector through an attached approximate madd netlist and
// accumulates max error, error count and first over-threshold vector.
//
// state    | meaning
// S_IDLE   | waiting for start; results and last stimulus held
// S_SETTLE | stimulus applied, wait counter runs down to terminal count
// S_SAMPLE | netlist response scored against the exact function
// S_DONE   | one-cycle done pulse, pass verdict presented
module madd_err_evaluator
    import madd_eval_pkg::*;
#(
    parameter int N_IN   = 6,
    parameter int N_OUT  = 4,
    parameter int ET     = 5,
    parameter int SETTLE = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [N_IN-1:0]  dut_in,
    input  logic [N_OUT-1:0] dut_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [N_OUT:0]   max_err,
    output logic [N_IN:0]    err_count,
    output logic [N_IN-1:0]  first_fail,
    output logic             fail_seen
);

    localparam logic [N_OUT:0] ET_V        = (N_OUT+1)'(ET);
    localparam logic [3:0]     SETTLE_LOAD = 4'(SETTLE - 1);

    eval_state_t      state;
    eval_state_t      state_nxt;
    logic [N_IN-1:0]  vec;
    logic [3:0]       wait_cnt;
    logic [N_OUT:0]   exact;
    logic [N_OUT:0]   err;
    logic [N_OUT:0]   max_nxt;
    logic             last_vec;
    logic             wait_tc;

    assign exact    = exact_madd(vec);
    assign last_vec = (vec == {N_IN{1'b1}});
    assign wait_tc  = (wait_cnt == 4'd0);
    assign max_nxt  = (err > max_err) ? err : max_err;

    madd_abs_err #(
        .W(N_OUT + 1)
    ) u_abs_err (
        .exact  (exact),
        .approx ({1'b0, dut_out}),
        .abs_err(err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:   if (start) state_nxt = S_SETTLE;
            S_SETTLE: if (wait_tc) state_nxt = S_SAMPLE;
            S_SAMPLE: state_nxt = last_vec ? S_DONE : S_SETTLE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    assign busy   = (state == S_SETTLE) || (state == S_SAMPLE);
    assign done   = (state == S_DONE);
    assign dut_in = vec;

    // pass is resolved on the final sample so it is already valid during done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec        <= '0;
            wait_cnt   <= '0;
            max_err    <= '0;
            err_count  <= '0;
            first_fail <= '0;
            fail_seen  <= 1'b0;
            pass       <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        vec        <= '0;
                        wait_cnt   <= SETTLE_LOAD;
                        max_err    <= '0;
                        err_count  <= '0;
                        first_fail <= '0;
                        fail_seen  <= 1'b0;
                        pass       <= 1'b0;
                    end
                end
                S_SETTLE: begin
                    if (!wait_tc) begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                S_SAMPLE: begin
                    max_err <= max_nxt;
                    if (err != '0) begin
                        err_count <= err_count + 1'b1;
                    end
                    if ((err > ET_V) && !fail_seen) begin
                        first_fail <= vec;
                        fail_seen  <= 1'b1;
                    end
                    if (last_vec) begin
                        pass <= (max_nxt <= ET_V);
                    end else begin
                        vec      <= vec + 1'b1;
                        wait_cnt <= SETTLE_LOAD;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_madd_err_evaluator.sv
// Self-checking bench: behavioural netlist stand-ins driven by the evaluator,
// results compared against an arithmetic reference sweep.
module tb_madd_err_evaluator;

    localparam int ET       = 5;
    localparam int SETTLE_A = 2;
    localparam int SETTLE_B = 1;
    localparam int NVEC     = 64;
    localparam int BUDGET   = 1000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_a, start_b;
    logic [5:0] dut_in_a, dut_in_b;
    logic [3:0] dut_out_a, dut_out_b;
    logic       busy_a, done_a, pass_a, fail_seen_a;
    logic       busy_b, done_b, pass_b, fail_seen_b;
    logic [4:0] max_err_a, max_err_b;
    logic [6:0] err_count_a, err_count_b;
    logic [5:0] first_fail_a, first_fail_b;

    int         n_cmp = 0;
    int         n_err = 0;
    int         mode  = 0;
    logic [3:0] rand_tab [NVEC];

    always #5 clk = ~clk;

    // Netlist stand-ins: 0 exact, 1 constant zero, 2 exact but 0x3F->15,
    // 3 exact+5 saturated, 4 random table
    function automatic logic [3:0] netlist(input int m, input logic [5:0] v);
        int ex;
        ex = int'(v[1:0]) * int'(v[3:2]) + int'(v[5:4]);
        case (m)
            0:       return 4'(ex);
            1:       return 4'd0;
            2:       return (v == 6'h3F) ? 4'd15 : 4'(ex);
            3:       return (ex + 5 > 15) ? 4'd15 : 4'(ex + 5);
            default: return rand_tab[v];
        endcase
    endfunction

    assign dut_out_a = netlist(mode, dut_in_a);
    assign dut_out_b = netlist(mode, dut_in_b);

    madd_err_evaluator #(.N_IN(6), .N_OUT(4), .ET(ET), .SETTLE(SETTLE_A)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .dut_in(dut_in_a), .dut_out(dut_out_a),
        .busy(busy_a), .done(done_a), .pass(pass_a), .max_err(max_err_a),
        .err_count(err_count_a), .first_fail(first_fail_a), .fail_seen(fail_seen_a)
    );

    madd_err_evaluator #(.N_IN(6), .N_OUT(4), .ET(ET), .SETTLE(SETTLE_B)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .dut_in(dut_in_b), .dut_out(dut_out_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .max_err(max_err_b),
        .err_count(err_count_b), .first_fail(first_fail_b), .fail_seen(fail_seen_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: walk all 64 (a,b,c) triples with plain integer arithmetic
    task automatic ref_model(input int m, output int emax, output int ecnt,
                             output int ffail, output int fseen, output int epass);
        emax = 0; ecnt = 0; ffail = 0; fseen = 0;
        for (int v = 0; v < NVEC; v++) begin
            int a, b, c, ex, ap, e;
            a  = v % 4;
            b  = (v / 4) % 4;
            c  = v / 16;
            ex = a * b + c;
            ap = int'(netlist(m, 6'(v)));
            e  = (ex > ap) ? ex - ap : ap - ex;
            if (e > emax) emax = e;
            if (e != 0) ecnt++;
            if (e > ET && fseen == 0) begin
                ffail = v;
                fseen = 1;
            end
        end
        epass = (emax <= ET) ? 1 : 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
        #2;
        n_cmp++;
        if ({busy_a, done_a, pass_a, max_err_a, err_count_a, first_fail_a, fail_seen_a, dut_in_a} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs_a: got busy=%b done=%b pass=%b max=%0d cnt=%0d ff=%0d fs=%b in=%0d, want all 0",
                     busy_a, done_a, pass_a, max_err_a, err_count_a, first_fail_a, fail_seen_a, dut_in_a);
        end
        n_cmp++;
        if ({busy_b, done_b, pass_b, max_err_b, err_count_b, first_fail_b, fail_seen_b, dut_in_b} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs_b: got nonzero output, want all 0");
        end
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_sweep(input int m, input string name, input bit repulse);
        int emax, ecnt, ffail, fseen, epass, lat;
        ref_model(m, emax, ecnt, ffail, fseen, epass);
        mode    = m;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        lat     = 1;
        n_cmp++;
        if (busy_a !== 1'b1 || dut_in_a !== 6'd0) begin
            n_err++;
            $display("FAIL %s_start: busy=%b dut_in=%0d, want busy=1 dut_in=0", name, busy_a, dut_in_a);
        end
        while (done_a !== 1'b1 && lat < BUDGET) begin
            start_a = (repulse && lat == 20);
            tick();
            lat++;
        end
        start_a = 1'b0;
        n_cmp++;
        if (lat != 1 + NVEC * (SETTLE_A + 1)) begin
            n_err++;
            $display("FAIL %s_latency: got %0d cycles, want %0d", name, lat, 1 + NVEC * (SETTLE_A + 1));
            return;
        end
        n_cmp++;
        if (max_err_a !== 5'(emax) || err_count_a !== 7'(ecnt)) begin
            n_err++;
            $display("FAIL %s_max_count: got max=%0d cnt=%0d, want max=%0d cnt=%0d",
                     name, max_err_a, err_count_a, emax, ecnt);
        end
        n_cmp++;
        if (first_fail_a !== 6'(ffail) || fail_seen_a !== 1'(fseen) || pass_a !== 1'(epass) || busy_a !== 1'b0) begin
            n_err++;
            $display("FAIL %s_verdict: got ff=%0d fs=%b pass=%b busy=%b, want ff=%0d fs=%0d pass=%0d busy=0",
                     name, first_fail_a, fail_seen_a, pass_a, busy_a, ffail, fseen, epass);
        end
        tick(); tick();
        n_cmp++;
        if (done_a !== 1'b0 || max_err_a !== 5'(emax) || pass_a !== 1'(epass) || dut_in_a !== 6'h3F) begin
            n_err++;
            $display("FAIL %s_hold: got done=%b max=%0d pass=%b in=%0d, want done=0 max=%0d pass=%0d in=63",
                     name, done_a, max_err_a, pass_a, dut_in_a, emax, epass);
        end
    endtask

    task automatic test_reset_mid_sweep();
        int dones;
        mode    = 1;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int i = 0; i < 50; i++) tick();
        n_cmp++;
        if (max_err_a == 5'd0 || busy_a !== 1'b1) begin
            n_err++;
            $display("FAIL midsweep_progress: got max=%0d busy=%b, want max>0 busy=1", max_err_a, busy_a);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy_a, done_a, pass_a, max_err_a, err_count_a, first_fail_a, fail_seen_a, dut_in_a} !== '0) begin
            n_err++;
            $display("FAIL midsweep_async_reset: got max=%0d cnt=%0d in=%0d busy=%b, want all 0",
                     max_err_a, err_count_a, dut_in_a, busy_a);
        end
        tick(); tick();
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (done_a === 1'b1 || busy_a === 1'b1) dones++;
        end
        n_cmp++;
        if (dones != 0) begin
            n_err++;
            $display("FAIL midsweep_no_done: got %0d active cycles after reset, want 0", dones);
        end
    endtask

    task automatic test_settle_one(input int m);
        int emax, ecnt, ffail, fseen, epass, lat;
        ref_model(m, emax, ecnt, ffail, fseen, epass);
        mode    = m;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        lat     = 1;
        while (done_b !== 1'b1 && lat < BUDGET) begin
            tick();
            lat++;
        end
        n_cmp++;
        if (lat != 1 + NVEC * (SETTLE_B + 1)) begin
            n_err++;
            $display("FAIL settle1_latency: got %0d cycles, want %0d", lat, 1 + NVEC * (SETTLE_B + 1));
            return;
        end
        n_cmp++;
        if (max_err_b !== 5'(emax) || err_count_b !== 7'(ecnt) || first_fail_b !== 6'(ffail)
            || fail_seen_b !== 1'(fseen) || pass_b !== 1'(epass)) begin
            n_err++;
            $display("FAIL settle1_results: got max=%0d cnt=%0d ff=%0d fs=%b pass=%b, want %0d %0d %0d %0d %0d",
                     max_err_b, err_count_b, first_fail_b, fail_seen_b, pass_b, emax, ecnt, ffail, fseen, epass);
        end
        tick();
    endtask

    task automatic fill_random();
        for (int v = 0; v < NVEC; v++) begin
            int ex;
            ex = (v % 4) * ((v / 4) % 4) + v / 16;
            rand_tab[v] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'(ex);
        end
    endtask

    initial begin
        for (int v = 0; v < NVEC; v++) rand_tab[v] = 4'd0;
        test_reset();
        test_sweep(0, "exact", 1'b0);
        test_sweep(1, "const_zero", 1'b0);
        test_sweep(2, "single_high", 1'b0);
        test_sweep(3, "boundary_et", 1'b0);
        test_sweep(0, "restart_ignored", 1'b1);
        for (int r = 0; r < 3; r++) begin
            fill_random();
            test_sweep(4, "random", 1'b0);
        end
        test_reset_mid_sweep();
        test_sweep(0, "after_reset", 1'b0);
        test_settle_one(1);
        fill_random();
        test_settle_one(4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
